// File: rtl/axi_pkg.sv
// Shared AXI encodings and FSM state types for the AXI RAM slave and the
// bridge/interconnect benches that talk to it.
// Contents: burst and response encodings, write/read FSM state enums, and
// burst helpers (supported-burst check, next-beat address).
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Only FIXED and INCR are served; WRAP and the reserved code are errors.
  function automatic logic burst_ok(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

  // INCR advances with full 32-bit arithmetic so a burst can walk off the
  // top of memory and be flagged as out of range.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst);
    return (burst == BURST_INCR) ? addr + 32'd4 : addr;
  endfunction

endpackage

// File: rtl/slave_axi_ram_if.sv
// AXI4 channel bundle between a master (bridge, interconnect, bench) and the
// AXI RAM slave. Signal names follow the bus-side channel naming.
// Channels: write address, write data, write response, read address,
// read data. Modports: slave (the RAM side), master (the requester side).
interface slave_axi_ram_if #(
  parameter int ID_WIDTH = 2
);

  logic [ID_WIDTH-1:0] S_WR_ADDR_ID;
  logic [31:0]         S_WR_ADDR;
  logic [7:0]          S_WR_ADDR_LEN;
  logic [1:0]          S_WR_ADDR_BURST;
  logic                S_WR_ADDR_VALID;
  logic                S_WR_ADDR_READY;

  logic [31:0]         S_WR_DATA;
  logic [3:0]          S_WR_STRB;
  logic                S_WR_DATA_LAST;
  logic                S_WR_DATA_VALID;
  logic                S_WR_DATA_READY;

  logic [ID_WIDTH-1:0] S_WR_BACK_ID;
  logic [1:0]          S_WR_BACK_RESP;
  logic                S_WR_BACK_VALID;
  logic                S_WR_BACK_READY;

  logic [ID_WIDTH-1:0] S_RD_ADDR_ID;
  logic [31:0]         S_RD_ADDR;
  logic [7:0]          S_RD_ADDR_LEN;
  logic [1:0]          S_RD_ADDR_BURST;
  logic                S_RD_ADDR_VALID;
  logic                S_RD_ADDR_READY;

  logic [ID_WIDTH-1:0] S_RD_BACK_ID;
  logic [31:0]         S_RD_DATA;
  logic [1:0]          S_RD_DATA_RESP;
  logic                S_RD_DATA_LAST;
  logic                S_RD_DATA_VALID;
  logic                S_RD_DATA_READY;

  modport slave (
    input  S_WR_ADDR_ID, S_WR_ADDR, S_WR_ADDR_LEN, S_WR_ADDR_BURST, S_WR_ADDR_VALID,
    output S_WR_ADDR_READY,
    input  S_WR_DATA, S_WR_STRB, S_WR_DATA_LAST, S_WR_DATA_VALID,
    output S_WR_DATA_READY,
    output S_WR_BACK_ID, S_WR_BACK_RESP, S_WR_BACK_VALID,
    input  S_WR_BACK_READY,
    input  S_RD_ADDR_ID, S_RD_ADDR, S_RD_ADDR_LEN, S_RD_ADDR_BURST, S_RD_ADDR_VALID,
    output S_RD_ADDR_READY,
    output S_RD_BACK_ID, S_RD_DATA, S_RD_DATA_RESP, S_RD_DATA_LAST, S_RD_DATA_VALID,
    input  S_RD_DATA_READY
  );

  modport master (
    output S_WR_ADDR_ID, S_WR_ADDR, S_WR_ADDR_LEN, S_WR_ADDR_BURST, S_WR_ADDR_VALID,
    input  S_WR_ADDR_READY,
    output S_WR_DATA, S_WR_STRB, S_WR_DATA_LAST, S_WR_DATA_VALID,
    input  S_WR_DATA_READY,
    input  S_WR_BACK_ID, S_WR_BACK_RESP, S_WR_BACK_VALID,
    output S_WR_BACK_READY,
    output S_RD_ADDR_ID, S_RD_ADDR, S_RD_ADDR_LEN, S_RD_ADDR_BURST, S_RD_ADDR_VALID,
    input  S_RD_ADDR_READY,
    input  S_RD_BACK_ID, S_RD_DATA, S_RD_DATA_RESP, S_RD_DATA_LAST, S_RD_DATA_VALID,
    output S_RD_DATA_READY
  );

endinterface

// File: rtl/slave_axi_ram_mem.sv
// Word-addressed 32-bit RAM backing the AXI slave.
// Ports: clk_i clock; we_i/waddr_i/wstrb_i/wdata_i byte-enable write port;
// raddr_i/rdata_o combinational read port. A read and a write to the same
// word in one cycle return the old contents. Contents survive reset.
module slave_axi_ram_mem #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [3:0]            wstrb_i,
  input  logic [31:0]           wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/slave_axi_ram.sv
// AXI4 slave endpoint backed by on-chip RAM; write and read channels run
// independently. Ports: S_CLK sole clock; S_RSTN async active-low reset;
// bus (slave modport) carrying AW/W/B/AR/R channels.
//
// state  | meaning
// W_IDLE | waiting for a write address, AWREADY high
// W_DATA | accepting write beats, WREADY high
// W_RESP | presenting the write response, BVALID high
// R_IDLE | waiting for a read address, ARREADY high
// R_DATA | presenting a read beat, RVALID high
module slave_axi_ram
  import axi_pkg::*;
#(
  parameter int ID_WIDTH       = 2,
  parameter int MEM_DEPTH_LOG2 = 10
) (
  input logic           S_CLK,
  input logic           S_RSTN,
  slave_axi_ram_if.slave bus
);

  localparam logic [32:0] MEM_BYTES = 33'd4 << MEM_DEPTH_LOG2;

  function automatic logic in_range(input logic [31:0] addr);
    return {1'b0, addr} < MEM_BYTES;
  endfunction

  // Write channel state
  wr_state_t           wr_state_q;
  logic [ID_WIDTH-1:0] aw_id_q;
  logic [31:0]         aw_addr_q;
  logic [7:0]          aw_len_q;
  logic [1:0]          aw_burst_q;
  logic [7:0]          wr_cnt_q;
  logic                wr_err_q;
  logic [1:0]          bresp_q;

  // Read channel state; rd_addr_q always points at the next beat to load
  rd_state_t           rd_state_q;
  logic [ID_WIDTH-1:0] rd_id_q;
  logic [31:0]         rd_addr_q;
  logic [7:0]          rd_len_q;
  logic [1:0]          rd_burst_q;
  logic [7:0]          rd_cnt_q;
  logic [31:0]         rdata_q;
  logic [1:0]          rresp_q;
  logic                rlast_q;

  logic        aw_hs, w_hs, w_final, w_beat_ok, wr_err_d;
  logic        ar_hs, r_hs, rd_beat_ok;
  logic [31:0] rd_beat_addr, mem_rdata, rd_beat_data;
  logic [1:0]  rd_beat_burst, rd_beat_resp;
  logic [7:0]  rd_cnt_d;

  assign bus.S_WR_ADDR_READY = S_RSTN && (wr_state_q == W_IDLE);
  assign bus.S_WR_DATA_READY = S_RSTN && (wr_state_q == W_DATA);
  assign bus.S_WR_BACK_VALID = S_RSTN && (wr_state_q == W_RESP);
  assign bus.S_RD_ADDR_READY = S_RSTN && (rd_state_q == R_IDLE);
  assign bus.S_RD_DATA_VALID = S_RSTN && (rd_state_q == R_DATA);

  assign bus.S_WR_BACK_ID   = aw_id_q;
  assign bus.S_WR_BACK_RESP = bresp_q;
  assign bus.S_RD_BACK_ID   = rd_id_q;
  assign bus.S_RD_DATA      = rdata_q;
  assign bus.S_RD_DATA_RESP = rresp_q;
  assign bus.S_RD_DATA_LAST = rlast_q;

  assign aw_hs     = bus.S_WR_ADDR_VALID && bus.S_WR_ADDR_READY;
  assign w_hs      = bus.S_WR_DATA_VALID && bus.S_WR_DATA_READY;
  assign w_final   = (wr_cnt_q == aw_len_q);
  assign w_beat_ok = burst_ok(aw_burst_q) && in_range(aw_addr_q);
  // LAST is only checked, never trusted: the counter decides burst end.
  assign wr_err_d  = wr_err_q || !w_beat_ok || (bus.S_WR_DATA_LAST != w_final);

  assign ar_hs = bus.S_RD_ADDR_VALID && bus.S_RD_ADDR_READY;
  assign r_hs  = bus.S_RD_DATA_VALID && bus.S_RD_DATA_READY;

  // Beat 0 is fetched straight from the AR channel; later beats from rd_addr_q.
  assign rd_beat_addr  = (rd_state_q == R_IDLE) ? bus.S_RD_ADDR : rd_addr_q;
  assign rd_beat_burst = (rd_state_q == R_IDLE) ? bus.S_RD_ADDR_BURST : rd_burst_q;
  assign rd_beat_ok    = burst_ok(rd_beat_burst) && in_range(rd_beat_addr);
  assign rd_beat_data  = rd_beat_ok ? mem_rdata : 32'd0;
  assign rd_beat_resp  = rd_beat_ok ? RESP_OKAY : RESP_SLVERR;
  assign rd_cnt_d      = rd_cnt_q + 8'd1;

  slave_axi_ram_mem #(.DEPTH_LOG2(MEM_DEPTH_LOG2)) u_mem (
    .clk_i   (S_CLK),
    .we_i    (w_hs && w_beat_ok),
    .waddr_i (aw_addr_q[MEM_DEPTH_LOG2+1:2]),
    .wstrb_i (bus.S_WR_STRB),
    .wdata_i (bus.S_WR_DATA),
    .raddr_i (rd_beat_addr[MEM_DEPTH_LOG2+1:2]),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge S_CLK or negedge S_RSTN) begin
    if (!S_RSTN) begin
      wr_state_q <= W_IDLE;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_burst_q <= '0;
      wr_cnt_q   <= '0;
      wr_err_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      case (wr_state_q)
        W_IDLE: if (aw_hs) begin
          aw_id_q    <= bus.S_WR_ADDR_ID;
          aw_addr_q  <= bus.S_WR_ADDR;
          aw_len_q   <= bus.S_WR_ADDR_LEN;
          aw_burst_q <= bus.S_WR_ADDR_BURST;
          wr_cnt_q   <= '0;
          wr_err_q   <= 1'b0;
          bresp_q    <= RESP_OKAY;
          wr_state_q <= W_DATA;
        end
        W_DATA: if (w_hs) begin
          aw_addr_q <= next_addr(aw_addr_q, aw_burst_q);
          wr_err_q  <= wr_err_d;
          if (w_final) begin
            bresp_q    <= wr_err_d ? RESP_SLVERR : RESP_OKAY;
            wr_state_q <= W_RESP;
          end else begin
            wr_cnt_q <= wr_cnt_q + 8'd1;
          end
        end
        W_RESP: if (bus.S_WR_BACK_READY) wr_state_q <= W_IDLE;
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge S_CLK or negedge S_RSTN) begin
    if (!S_RSTN) begin
      rd_state_q <= R_IDLE;
      rd_id_q    <= '0;
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
      rd_burst_q <= '0;
      rd_cnt_q   <= '0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rlast_q    <= 1'b0;
    end else begin
      case (rd_state_q)
        R_IDLE: if (ar_hs) begin
          rd_id_q    <= bus.S_RD_ADDR_ID;
          rd_len_q   <= bus.S_RD_ADDR_LEN;
          rd_burst_q <= bus.S_RD_ADDR_BURST;
          rd_addr_q  <= next_addr(bus.S_RD_ADDR, bus.S_RD_ADDR_BURST);
          rd_cnt_q   <= '0;
          rdata_q    <= rd_beat_data;
          rresp_q    <= rd_beat_resp;
          rlast_q    <= (bus.S_RD_ADDR_LEN == 8'd0);
          rd_state_q <= R_DATA;
        end
        R_DATA: if (r_hs) begin
          if (rd_cnt_q == rd_len_q) begin
            rd_state_q <= R_IDLE;
          end else begin
            rd_cnt_q  <= rd_cnt_d;
            rd_addr_q <= next_addr(rd_addr_q, rd_burst_q);
            rdata_q   <= rd_beat_data;
            rresp_q   <= rd_beat_resp;
            rlast_q   <= (rd_cnt_d == rd_len_q);
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slave_axi_ram.sv
// Directed bench for the AXI RAM slave: INCR/FIXED writes, strobes, out of
// range beats, backpressure, LAST errors, WRAP reads, concurrent channels,
// same-word collision and reset during a read burst.
module tb_slave_axi_ram;
  import axi_pkg::*;

  localparam int IDW = 2;
  localparam int DL  = 10;
  localparam logic [31:0] TOP_WORD = (32'd4 << DL) - 32'd4;

  logic S_CLK  = 1'b0;
  logic S_RSTN = 1'b0;
  always #5 S_CLK = ~S_CLK;

  slave_axi_ram_if #(.ID_WIDTH(IDW)) bus ();

  slave_axi_ram #(.ID_WIDTH(IDW), .MEM_DEPTH_LOG2(DL)) dut (
    .S_CLK  (S_CLK),
    .S_RSTN (S_RSTN),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0]    wdat [16];
  logic [3:0]     wstrb [16];
  logic [31:0]    rdat [16];
  logic [1:0]     rrsp [16];
  logic           rlst [16];
  logic [IDW-1:0] rid_got;
  logic [31:0]    edat [16];
  logic [1:0]     ersp [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic axi_write(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int last_beat, input int b_hold,
                           output logic [IDW-1:0] bid, output logic [1:0] bresp,
                           output int b_lat, output int beats);
    int t;
    bus.S_WR_ADDR_ID    = id;
    bus.S_WR_ADDR       = addr;
    bus.S_WR_ADDR_LEN   = len;
    bus.S_WR_ADDR_BURST = burst;
    bus.S_WR_ADDR_VALID = 1'b1;
    t = 0;
    while (!bus.S_WR_ADDR_READY && t < 20) begin @(negedge S_CLK); t++; end
    chk("aw_ready", 32'(bus.S_WR_ADDR_READY), 32'd1);
    @(posedge S_CLK); @(negedge S_CLK);
    bus.S_WR_ADDR_VALID = 1'b0;
    beats = 0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.S_WR_DATA       = wdat[i % 16];
      bus.S_WR_STRB       = wstrb[i % 16];
      bus.S_WR_DATA_LAST  = (last_beat < 0) ? (i == int'(len)) : (i == last_beat);
      bus.S_WR_DATA_VALID = 1'b1;
      t = 0;
      while (!bus.S_WR_DATA_READY && t < 20) begin @(negedge S_CLK); t++; end
      chk("w_ready", 32'(bus.S_WR_DATA_READY), 32'd1);
      @(posedge S_CLK); beats++; @(negedge S_CLK);
    end
    bus.S_WR_DATA_VALID = 1'b0;
    bus.S_WR_DATA_LAST  = 1'b0;
    t = 0;
    while (!bus.S_WR_BACK_VALID && t < 20) begin @(negedge S_CLK); t++; end
    b_lat = t;
    chk("b_valid", 32'(bus.S_WR_BACK_VALID), 32'd1);
    for (int k = 0; k < b_hold; k++) begin
      chk("b_hold_valid", 32'(bus.S_WR_BACK_VALID), 32'd1);
      chk("b_hold_awready", 32'(bus.S_WR_ADDR_READY), 32'd0);
      @(negedge S_CLK);
    end
    bid   = bus.S_WR_BACK_ID;
    bresp = bus.S_WR_BACK_RESP;
    bus.S_WR_BACK_READY = 1'b1;
    @(posedge S_CLK); @(negedge S_CLK);
    bus.S_WR_BACK_READY = 1'b0;
  endtask

  // pat[cycle%4] drives RREADY; stalled beats are checked for stability.
  task automatic axi_read(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [3:0] pat);
    int t, cyc, beats;
    logic stalled, pl;
    logic [31:0] pd;
    logic [1:0] pr;
    bus.S_RD_ADDR_ID    = id;
    bus.S_RD_ADDR       = addr;
    bus.S_RD_ADDR_LEN   = len;
    bus.S_RD_ADDR_BURST = burst;
    bus.S_RD_ADDR_VALID = 1'b1;
    t = 0;
    while (!bus.S_RD_ADDR_READY && t < 20) begin @(negedge S_CLK); t++; end
    chk("ar_ready", 32'(bus.S_RD_ADDR_READY), 32'd1);
    @(posedge S_CLK); @(negedge S_CLK);
    bus.S_RD_ADDR_VALID = 1'b0;
    chk("r_first_valid", 32'(bus.S_RD_DATA_VALID), 32'd1);
    beats = 0; cyc = 0; stalled = 1'b0; pd = '0; pr = '0; pl = 1'b0;
    while (beats <= int'(len) && cyc < 100) begin
      bus.S_RD_DATA_READY = pat[2'(cyc)];
      if (stalled) begin
        chk("r_hold_valid", 32'(bus.S_RD_DATA_VALID), 32'd1);
        chk("r_hold_data", bus.S_RD_DATA, pd);
        chk("r_hold_resp", 32'(bus.S_RD_DATA_RESP), 32'(pr));
        chk("r_hold_last", 32'(bus.S_RD_DATA_LAST), 32'(pl));
      end
      if (bus.S_RD_DATA_VALID && bus.S_RD_DATA_READY) begin
        if (beats < 16) begin
          rdat[beats] = bus.S_RD_DATA;
          rrsp[beats] = bus.S_RD_DATA_RESP;
          rlst[beats] = bus.S_RD_DATA_LAST;
        end
        rid_got = bus.S_RD_BACK_ID;
        beats++;
      end
      stalled = bus.S_RD_DATA_VALID && !bus.S_RD_DATA_READY;
      pd = bus.S_RD_DATA; pr = bus.S_RD_DATA_RESP; pl = bus.S_RD_DATA_LAST;
      @(posedge S_CLK); @(negedge S_CLK);
      cyc++;
    end
    bus.S_RD_DATA_READY = 1'b0;
    chk("r_beats", beats, int'(len) + 1);
    chk("r_done_valid", 32'(bus.S_RD_DATA_VALID), 32'd0);
    chk("r_done_arready", 32'(bus.S_RD_ADDR_READY), 32'd1);
  endtask

  task automatic cmp_read(input string tag, input int len, input logic [IDW-1:0] id);
    for (int i = 0; i <= len; i++) begin
      chk($sformatf("%s_data%0d", tag, i), rdat[i], edat[i]);
      chk($sformatf("%s_resp%0d", tag, i), 32'(rrsp[i]), 32'(ersp[i]));
      chk($sformatf("%s_last%0d", tag, i), 32'(rlst[i]), 32'(i == len));
    end
    chk($sformatf("%s_id", tag), 32'(rid_got), 32'(id));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [IDW-1:0] bid;
    logic [1:0] bresp;
    int blat, wbeats;

    bus.S_WR_ADDR_ID = '0; bus.S_WR_ADDR = '0; bus.S_WR_ADDR_LEN = '0; bus.S_WR_ADDR_BURST = '0;
    bus.S_WR_ADDR_VALID = 1'b0; bus.S_WR_DATA = '0; bus.S_WR_STRB = '0; bus.S_WR_DATA_LAST = 1'b0;
    bus.S_WR_DATA_VALID = 1'b0; bus.S_WR_BACK_READY = 1'b0;
    bus.S_RD_ADDR_ID = '0; bus.S_RD_ADDR = '0; bus.S_RD_ADDR_LEN = '0; bus.S_RD_ADDR_BURST = '0;
    bus.S_RD_ADDR_VALID = 1'b0; bus.S_RD_DATA_READY = 1'b0;
    for (int i = 0; i < 16; i++) begin wstrb[i] = 4'hF; wdat[i] = '0; end

    // Reset state
    repeat (3) @(negedge S_CLK);
    chk("rst_awready", 32'(bus.S_WR_ADDR_READY), 32'd0);
    chk("rst_wready",  32'(bus.S_WR_DATA_READY), 32'd0);
    chk("rst_bvalid",  32'(bus.S_WR_BACK_VALID), 32'd0);
    chk("rst_arready", 32'(bus.S_RD_ADDR_READY), 32'd0);
    chk("rst_rvalid",  32'(bus.S_RD_DATA_VALID), 32'd0);
    chk("rst_rdata",   bus.S_RD_DATA, 32'd0);
    chk("rst_rlast",   32'(bus.S_RD_DATA_LAST), 32'd0);
    chk("rst_bid",     32'(bus.S_WR_BACK_ID), 32'd0);
    S_RSTN = 1'b1;
    @(negedge S_CLK);
    chk("idle_awready", 32'(bus.S_WR_ADDR_READY), 32'd1);
    chk("idle_arready", 32'(bus.S_RD_ADDR_READY), 32'd1);

    // INCR write then read
    for (int i = 0; i < 4; i++) wdat[i] = 32'hA0 + 32'(i);
    axi_write(2'd1, 32'h10, 8'd3, BURST_INCR, -1, 0, bid, bresp, blat, wbeats);
    chk("t1_bid", 32'(bid), 32'd1);
    chk("t1_bresp", 32'(bresp), 32'(RESP_OKAY));
    chk("t1_blat", blat, 0);
    chk("t1_wbeats", wbeats, 4);
    axi_read(2'd2, 32'h10, 8'd3, BURST_INCR, 4'b1111);
    for (int i = 0; i < 4; i++) begin edat[i] = 32'hA0 + 32'(i); ersp[i] = RESP_OKAY; end
    cmp_read("t1_rd", 3, 2'd2);

    // Partial strobe with FIXED burst
    wdat[0] = 32'hFFFF_FFFF;
    axi_write(2'd0, 32'h40, 8'd0, BURST_INCR, -1, 0, bid, bresp, blat, wbeats);
    chk("t2_fill_bresp", 32'(bresp), 32'(RESP_OKAY));
    wdat[0] = 32'h11;        wstrb[0] = 4'b0001;
    wdat[1] = 32'h2200_0000; wstrb[1] = 4'b1000;
    axi_write(2'd2, 32'h40, 8'd1, BURST_FIXED, -1, 0, bid, bresp, blat, wbeats);
    chk("t2_fixed_bresp", 32'(bresp), 32'(RESP_OKAY));
    wstrb[0] = 4'hF; wstrb[1] = 4'hF;
    axi_read(2'd0, 32'h40, 8'd0, BURST_INCR, 4'b1111);
    edat[0] = 32'h22FF_FF11; ersp[0] = RESP_OKAY;
    cmp_read("t2_rd", 0, 2'd0);

    // Out of range at the top of memory
    wdat[0] = 32'h1234_5678;
    axi_write(2'd0, 32'h0, 8'd0, BURST_INCR, -1, 0, bid, bresp, blat, wbeats);
    wdat[0] = 32'hB0; wdat[1] = 32'hB1;
    axi_write(2'd3, TOP_WORD, 8'd1, BURST_INCR, -1, 0, bid, bresp, blat, wbeats);
    chk("t3_bresp", 32'(bresp), 32'(RESP_SLVERR));
    chk("t3_bid", 32'(bid), 32'd3);
    axi_read(2'd1, 32'h0, 8'd0, BURST_INCR, 4'b1111);
    edat[0] = 32'h1234_5678; ersp[0] = RESP_OKAY;
    cmp_read("t3_word0", 0, 2'd1);
    axi_read(2'd3, TOP_WORD, 8'd1, BURST_INCR, 4'b1111);
    edat[0] = 32'hB0; ersp[0] = RESP_OKAY;
    edat[1] = 32'h0;  ersp[1] = RESP_SLVERR;
    cmp_read("t3_oor", 1, 2'd3);

    // Backpressure on B and R
    for (int i = 0; i < 8; i++) wdat[i] = 32'hC0 + 32'(i);
    axi_write(2'd2, 32'h100, 8'd7, BURST_INCR, -1, 5, bid, bresp, blat, wbeats);
    chk("t4_bresp", 32'(bresp), 32'(RESP_OKAY));
    axi_read(2'd1, 32'h100, 8'd7, BURST_INCR, 4'b1001);
    for (int i = 0; i < 8; i++) begin edat[i] = 32'hC0 + 32'(i); ersp[i] = RESP_OKAY; end
    cmp_read("t4_rd", 7, 2'd1);

    // Early WLAST, then a WRAP read
    for (int i = 0; i < 4; i++) wdat[i] = 32'hD0 + 32'(i);
    axi_write(2'd1, 32'h200, 8'd3, BURST_INCR, 1, 0, bid, bresp, blat, wbeats);
    chk("t5_wbeats", wbeats, 4);
    chk("t5_bresp", 32'(bresp), 32'(RESP_SLVERR));
    axi_read(2'd0, 32'h10, 8'd1, 2'b10, 4'b1111);
    edat[0] = 32'h0; ersp[0] = RESP_SLVERR;
    edat[1] = 32'h0; ersp[1] = RESP_SLVERR;
    cmp_read("t5_wrap", 1, 2'd0);

    // Simultaneous AW and AR
    wdat[0] = 32'h77;
    fork
      axi_write(2'd1, 32'h20, 8'd0, BURST_INCR, -1, 0, bid, bresp, blat, wbeats);
      axi_read(2'd2, 32'h14, 8'd0, BURST_INCR, 4'b1111);
    join
    chk("t6_conc_bresp", 32'(bresp), 32'(RESP_OKAY));
    edat[0] = 32'hA1; ersp[0] = RESP_OKAY;
    cmp_read("t6_conc_rd", 0, 2'd2);

    // Same-word collision: AR handshake lands on the W beat edge
    wdat[0] = 32'h55;
    fork
      axi_write(2'd0, 32'h10, 8'd0, BURST_INCR, -1, 0, bid, bresp, blat, wbeats);
      begin
        @(negedge S_CLK);
        axi_read(2'd3, 32'h10, 8'd0, BURST_INCR, 4'b1111);
      end
    join
    edat[0] = 32'hA0; ersp[0] = RESP_OKAY;
    cmp_read("t6_coll_old", 0, 2'd3);
    axi_read(2'd3, 32'h10, 8'd0, BURST_INCR, 4'b1111);
    edat[0] = 32'h55;
    cmp_read("t6_coll_new", 0, 2'd3);

    // Reset during R_DATA
    bus.S_RD_ADDR_ID = 2'd1; bus.S_RD_ADDR = 32'h100; bus.S_RD_ADDR_LEN = 8'd7;
    bus.S_RD_ADDR_BURST = BURST_INCR; bus.S_RD_ADDR_VALID = 1'b1;
    @(posedge S_CLK); @(negedge S_CLK);
    bus.S_RD_ADDR_VALID = 1'b0;
    chk("t7_pre_rvalid", 32'(bus.S_RD_DATA_VALID), 32'd1);
    S_RSTN = 1'b0;
    #1;
    chk("t7_rvalid", 32'(bus.S_RD_DATA_VALID), 32'd0);
    chk("t7_arready", 32'(bus.S_RD_ADDR_READY), 32'd0);
    chk("t7_awready", 32'(bus.S_WR_ADDR_READY), 32'd0);
    chk("t7_wready", 32'(bus.S_WR_DATA_READY), 32'd0);
    chk("t7_bvalid", 32'(bus.S_WR_BACK_VALID), 32'd0);
    chk("t7_rdata", bus.S_RD_DATA, 32'd0);
    @(negedge S_CLK);
    S_RSTN = 1'b1;
    @(negedge S_CLK);
    axi_read(2'd2, 32'h100, 8'd0, BURST_INCR, 4'b1111);
    edat[0] = 32'hC0; ersp[0] = RESP_OKAY;
    cmp_read("t7_after", 0, 2'd2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/slave_axi_ram.md
# slave_axi_ram

Single-clock AXI4 slave endpoint that terminates the bus-side AXI channels produced by the master async bridge and the interconnect, backing them with an on-chip word-addressed memory. It accepts write and read bursts independently, so the write and read channels never block each other. It returns write responses on the write-back channel and read data on the read-back channel. It is the reference responder for bridge and interconnect bring-up and a general scratch RAM for the lab design.

## Interface
- ID_WIDTH, 2, width of all ID fields
- MEM_DEPTH_LOG2, 10, log2 of the number of 32-bit words (default 4 KiB)
- S_CLK  in  1  sole clock
- S_RSTN  in  1  asynchronous active-low reset; all state clears immediately on assertion
- S_WR_ADDR_ID / S_WR_ADDR / S_WR_ADDR_LEN / S_WR_ADDR_BURST  in  ID_WIDTH/32/8/2  write address, beats-1, burst type
- S_WR_ADDR_VALID in 1; S_WR_ADDR_READY out 1
- S_WR_DATA / S_WR_STRB / S_WR_DATA_LAST  in  32/4/1  write beat
- S_WR_DATA_VALID in 1; S_WR_DATA_READY out 1
- S_WR_BACK_ID / S_WR_BACK_RESP  out  ID_WIDTH/2  write response
- S_WR_BACK_VALID out 1; S_WR_BACK_READY in 1
- S_RD_ADDR_ID / S_RD_ADDR / S_RD_ADDR_LEN / S_RD_ADDR_BURST  in  ID_WIDTH/32/8/2  read address
- S_RD_ADDR_VALID in 1; S_RD_ADDR_READY out 1
- S_RD_BACK_ID / S_RD_DATA / S_RD_DATA_RESP / S_RD_DATA_LAST  out  ID_WIDTH/32/2/1  read beat
- S_RD_DATA_VALID out 1; S_RD_DATA_READY in 1

## Operation

**Encodings**
- Burst types: FIXED = 2'b00, INCR = 2'b01. WRAP (2'b10) and 2'b11 are unsupported.
- Responses: OKAY = 2'b00, SLVERR = 2'b10.

**Addressing**
- Word index is `addr[MEM_DEPTH_LOG2+1:2]`; `addr[1:0]` is ignored.
- A beat is out of range when `addr >= 4<<MEM_DEPTH_LOG2`.
- INCR adds 4 per beat using full 32-bit arithmetic, so a burst may run past the top of memory and become out of range.
- FIXED keeps the same address for every beat.

**Write FSM: W_IDLE → W_DATA → W_RESP → W_IDLE**
- W_IDLE: S_WR_ADDR_READY = 1. On handshake, latch ID, address, LEN and burst; clear the beat counter and error flag.
- W_DATA: S_WR_DATA_READY = 1. Each handshake writes the bytes whose STRB bit is set, unless the burst is unsupported or the beat is out of range; such a beat is dropped and sets the error flag.
- Burst end is decided by the counter reaching LEN, never by LAST. If LAST is asserted on any beat other than the final one, or deasserted on the final one, the error flag is set.
- W_RESP: S_WR_BACK_VALID = 1 with the latched ID. RESP is SLVERR if the error flag is set, otherwise OKAY. RESP and ID are held stable until S_WR_BACK_READY.

**Read FSM: R_IDLE → R_DATA → R_IDLE**
- R_IDLE: S_RD_ADDR_READY = 1. On handshake, latch ID, LEN and burst; load the output register with beat 0.
- R_DATA: S_RD_DATA_VALID = 1. On each handshake, load the next beat, or return to R_IDLE after beat LEN.
- S_RD_DATA_LAST = 1 only on beat LEN.
- A beat that is out of range or belongs to an unsupported burst returns data 0 with SLVERR; every other beat returns OKAY.
- All read outputs are held stable while VALID is high and READY is low.

**Collisions and reset**
- A read and a write to the same word in the same cycle: the read returns the old data.
- Reset mid-burst aborts the burst: both FSMs go to IDLE and all VALIDs drop. Memory contents are not cleared.

## Timing
- Reset values: every READY and VALID is 0 while S_RSTN is low, and all ID/RESP/DATA/LAST outputs are 0. Both FSMs are in IDLE after reset.
- READYs and VALIDs are decoded from FSM state and gated by S_RSTN; no combinational path from any input VALID to any output READY.
- Write: first WREADY the cycle after the AW handshake; one beat per cycle; BVALID the cycle after the last W handshake. Minimum turnaround is 3 + LEN cycles.
- Read: first RVALID the cycle after the AR handshake; one beat per cycle under continuous RREADY. The next AR is accepted the cycle after the last R handshake.
- LEN = 255 yields 256 beats; the beat counter is 8 bits.

## Structure
- Package `axi_pkg` holds the BURST_* and RESP_* constants and the `wr_state_t` / `rd_state_t` enums; shared with the bridge benches.
- Sub-module `slave_axi_ram_mem`: 2^MEM_DEPTH_LOG2 × 32 array with a byte-enable write port and a combinational read port.
- Both FSMs, the address generators and the response logic stay in the top module.

## Test plan
- **INCR write then read:** AW addr 0x10, LEN 3, ID 1, data 0xA0..0xA3, STRB 4'hF, then AR addr 0x10, LEN 3 → BRESP OKAY with ID 1; R returns 0xA0, 0xA1, 0xA2, 0xA3, LAST only on the 4th beat.
- **Partial strobe and FIXED burst:** write 0xFFFFFFFF to 0x40, then a FIXED LEN 1 write to 0x40 with STRB 4'b0001, data 0x11, then STRB 4'b1000, data 0x22000000 → read of 0x40 returns 0x22FFFF11.
- **Out of range:** INCR write at `(4<<MEM_DEPTH_LOG2) - 4`, LEN 1 → BRESP SLVERR and word 0 unchanged; the matching read gives beat 0 OKAY, beat 1 data 0 with SLVERR.
- **Backpressure:** read of LEN 7 with RREADY toggling 1,0,0,1 → every beat is held stable while stalled, no beat is lost or duplicated, and LAST arrives on beat 8. Hold BREADY low 5 cycles → BVALID stays high and AWREADY stays low throughout.
- **Protocol error:** WLAST asserted on beat 1 of a LEN 3 write → 4 beats accepted, BRESP SLVERR. A WRAP burst read → all beats return data 0 with SLVERR.
- **Concurrency and reset:** a simultaneous AW and AR complete independently; a same-word collision returns old data. Asserting S_RSTN low during R_DATA → all VALID/READY outputs are 0 in that cycle, and the next AR is accepted normally after release.
